// File: rtl/udm_bus_arb.sv
// udm_bus_arb: two-master, single-slave round-robin bus arbiter with one
// outstanding transaction. Master 0 is the UDM debug master.
// Optional slave-phase timeout is compiled in with `define UDM_BUS_ARB_TIMEOUT_EN;
// without it, slave waits are unbounded and err_o is constant 0.
module udm_bus_arb #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        m0_req_i,
   output logic        m0_ack_o,
   input  logic [31:0] m0_addr_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_wdata_i,
   input  logic [3:0]  m0_be_i,
   output logic        m0_resp_o,
   output logic [31:0] m0_rdata_o,
   input  logic        m1_req_i,
   output logic        m1_ack_o,
   input  logic [31:0] m1_addr_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_wdata_i,
   input  logic [3:0]  m1_be_i,
   output logic        m1_resp_o,
   output logic [31:0] m1_rdata_o,
   output logic        s_req_o,
   input  logic        s_ack_i,
   output logic [31:0] s_addr_o,
   output logic        s_we_o,
   output logic [31:0] s_wdata_o,
   output logic [3:0]  s_be_o,
   input  logic        s_resp_i,
   input  logic [31:0] s_rdata_i,
   output logic        err_o
);

   typedef enum logic [1:0] {StIdle, StSreq, StRwait, StResp} state_e;

   state_e      state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic        gnt_q, gnt_d;
   logic [31:0] addr_q, addr_d;
   logic        we_q, we_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] rdata0_q, rdata0_d;
   logic [31:0] rdata1_q, rdata1_d;
   logic        pick_m0;
   logic        timeout;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

`ifdef UDM_BUS_ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Counter restarts on entry to SREQ and runs through SREQ and RWAIT.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == StIdle && (m0_req_i || m1_req_i)) begin
         cnt_d = '0;
      end else if (state_q == StSreq || state_q == StRwait) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   // Timeout counter register.
   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   // Fires in the TIMEOUT_CYCLES-th cycle spent in the slave phase.
   assign timeout = (state_q == StSreq || state_q == StRwait) &&
                    (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   // Next-state, arbitration and strobe generation.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      gnt_d        = gnt_q;
      addr_d       = addr_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      pick_m0      = 1'b0;
      m0_ack_o     = 1'b0;
      m1_ack_o     = 1'b0;
      m0_resp_o    = 1'b0;
      m1_resp_o    = 1'b0;
      s_req_o      = 1'b0;
      err_o        = 1'b0;

      unique case (state_q)
         StIdle: begin
            // m0 wins unless m1 also requests and m0 was served last.
            pick_m0 = m0_req_i && (!m1_req_i || last_grant_q);
            if (m0_req_i || m1_req_i) begin
               m0_ack_o     = pick_m0;
               m1_ack_o     = !pick_m0;
               gnt_d        = !pick_m0;
               last_grant_d = !pick_m0;
               addr_d       = pick_m0 ? m0_addr_i  : m1_addr_i;
               we_d         = pick_m0 ? m0_we_i    : m1_we_i;
               wdata_d      = pick_m0 ? m0_wdata_i : m1_wdata_i;
               be_d         = pick_m0 ? m0_be_i    : m1_be_i;
               state_d      = StSreq;
            end
         end
         StSreq, StRwait: begin
            if (timeout) begin
               err_o = 1'b1;
               if (we_q) begin
                  state_d = StIdle;
               end else begin
                  if (gnt_q) rdata1_d = 32'hDEADBEEF;
                  else       rdata0_d = 32'hDEADBEEF;
                  state_d = StResp;
               end
            end else if (state_q == StSreq) begin
               s_req_o = 1'b1;
               if (s_ack_i) state_d = we_q ? StIdle : StRwait;
            end else if (s_resp_i) begin
               if (gnt_q) rdata1_d = s_rdata_i;
               else       rdata0_d = s_rdata_i;
               state_d = StResp;
            end
         end
         StResp: begin
            m0_resp_o = !gnt_q;
            m1_resp_o = gnt_q;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Strobes stay quiet while reset is held, whatever the current state.
      if (rst_i) begin
         m0_ack_o  = 1'b0;
         m1_ack_o  = 1'b0;
         m0_resp_o = 1'b0;
         m1_resp_o = 1'b0;
         s_req_o   = 1'b0;
         err_o     = 1'b0;
      end
   end

   // State, grant and datapath registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         gnt_q        <= 1'b0;
         addr_q       <= '0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         be_q         <= '0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         gnt_q        <= gnt_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

   assign s_addr_o   = addr_q;
   assign s_we_o     = we_q;
   assign s_wdata_o  = wdata_q;
   assign s_be_o     = be_q;
   assign m0_rdata_o = rdata0_q;
   assign m1_rdata_o = rdata1_q;

endmodule

// File: tb/tb_udm_bus_arb.sv
// Directed testbench for udm_bus_arb. Inputs change 2 time units after a
// rising edge; outputs are checked 1 unit later, well away from the edge.
module tb_udm_bus_arb;

`ifdef UDM_BUS_ARB_TIMEOUT_EN
   localparam int unsigned TO = 16;
`else
   localparam int unsigned TO = 256;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        m0_req_i, m0_ack_o, m0_we_i, m0_resp_o;
   logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
   logic [3:0]  m0_be_i;
   logic        m1_req_i, m1_ack_o, m1_we_i, m1_resp_o;
   logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
   logic [3:0]  m1_be_i;
   logic        s_req_o, s_ack_i, s_we_o, s_resp_i, err_o;
   logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
   logic [3:0]  s_be_o;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] mem [0:15];
   logic [31:0] rd;

   always #5 clk_i = ~clk_i;

   udm_bus_arb #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_req_i(m0_req_i), .m0_ack_o(m0_ack_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
      .m0_wdata_i(m0_wdata_i), .m0_be_i(m0_be_i), .m0_resp_o(m0_resp_o),
      .m0_rdata_o(m0_rdata_o),
      .m1_req_i(m1_req_i), .m1_ack_o(m1_ack_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
      .m1_wdata_i(m1_wdata_i), .m1_be_i(m1_be_i), .m1_resp_o(m1_resp_o),
      .m1_rdata_o(m1_rdata_o),
      .s_req_o(s_req_o), .s_ack_i(s_ack_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
      .s_wdata_o(s_wdata_o), .s_be_o(s_be_o), .s_resp_i(s_resp_i), .s_rdata_i(s_rdata_i),
      .err_o(err_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // One m0 transfer against a zero-wait slave backed by mem[].
   task automatic m0_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata);
      m0_req_i = 1'b1; m0_we_i = we; m0_addr_i = addr; m0_wdata_i = wdata; m0_be_i = 4'hf;
      #1;
      chk("x_ack", {31'd0, m0_ack_o}, 32'd1);
      tick();
      m0_req_i = 1'b0; s_ack_i = 1'b1;
      #1;
      chk("x_sreq", {31'd0, s_req_o}, 32'd1);
      chk("x_addr", s_addr_o, addr);
      if (we) begin
         chk("x_wdata", s_wdata_o, wdata);
         mem[addr[5:2]] = s_wdata_o;
      end
      tick();
      s_ack_i = 1'b0;
      rdata = 32'd0;
      if (!we) begin
         s_resp_i = 1'b1; s_rdata_i = mem[addr[5:2]];
         tick();
         s_resp_i = 1'b0; s_rdata_i = 32'd0;
         #1;
         chk("x_resp", {31'd0, m0_resp_o}, 32'd1);
         chk("x_err", {31'd0, err_o}, 32'd0);
         rdata = m0_rdata_o;
         tick();
      end
   endtask

   initial begin
      rst_i = 1'b1;
      m0_req_i = 0; m0_we_i = 0; m0_addr_i = 0; m0_wdata_i = 0; m0_be_i = 0;
      m1_req_i = 0; m1_we_i = 0; m1_addr_i = 0; m1_wdata_i = 0; m1_be_i = 0;
      s_ack_i = 0; s_resp_i = 0; s_rdata_i = 0;
      for (int i = 0; i < 16; i++) mem[i] = 32'd0;

      // Reset state: no strobes even with both masters requesting.
      tick();
      m0_req_i = 1'b1; m1_req_i = 1'b1;
      #1;
      chk("rst_ack0", {31'd0, m0_ack_o}, 32'd0);
      chk("rst_ack1", {31'd0, m1_ack_o}, 32'd0);
      chk("rst_sreq", {31'd0, s_req_o}, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
      chk("rst_addr", s_addr_o, 32'd0);
      chk("rst_rdata0", m0_rdata_o, 32'd0);
      chk("rst_rdata1", m1_rdata_o, 32'd0);
      tick();
      rst_i = 1'b0; m0_req_i = 1'b0; m1_req_i = 1'b0;
      tick();

      // m0 write 0x33cc to address 0, slave acks immediately.
      m0_req_i = 1'b1; m0_we_i = 1'b1; m0_addr_i = 32'h0; m0_wdata_i = 32'h33cc; m0_be_i = 4'hf;
      #1;
      chk("w_ack0", {31'd0, m0_ack_o}, 32'd1);
      chk("w_ack1", {31'd0, m1_ack_o}, 32'd0);
      chk("w_sreq_t0", {31'd0, s_req_o}, 32'd0);
      tick();
      m0_req_i = 1'b0; s_ack_i = 1'b1;
      #1;
      chk("w_sreq", {31'd0, s_req_o}, 32'd1);
      chk("w_addr", s_addr_o, 32'h0);
      chk("w_wdata", s_wdata_o, 32'h33cc);
      chk("w_we", {31'd0, s_we_o}, 32'd1);
      chk("w_be", {28'd0, s_be_o}, 32'hf);
      tick();
      s_ack_i = 1'b0;

      // Back in IDLE at T+2: m1 read of 0x4 is accepted at once.
      m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 32'h4; m1_be_i = 4'hf;
      #1;
      chk("r_ack1", {31'd0, m1_ack_o}, 32'd1);
      chk("r_ack0", {31'd0, m0_ack_o}, 32'd0);
      chk("r_resp1_idle", {31'd0, m1_resp_o}, 32'd0);
      tick();
      m1_req_i = 1'b0;
      #1;
      chk("r_sreq_a", {31'd0, s_req_o}, 32'd1);
      chk("r_addr", s_addr_o, 32'h4);
      chk("r_we", {31'd0, s_we_o}, 32'd0);
      tick();
      #1;
      chk("r_sreq_b", {31'd0, s_req_o}, 32'd1);
      tick();
      s_ack_i = 1'b1;
      #1;
      chk("r_sreq_c", {31'd0, s_req_o}, 32'd1);
      chk("r_addr_c", s_addr_o, 32'h4);
      tick();
      s_ack_i = 1'b0;
      #1;
      chk("r_rwait_sreq", {31'd0, s_req_o}, 32'd0);
      tick();
      s_resp_i = 1'b1; s_rdata_i = 32'h30;
      #1;
      chk("r_resp_early", {31'd0, m1_resp_o}, 32'd0);
      tick();
      s_resp_i = 1'b0; s_rdata_i = 32'h0;
      #1;
      chk("r_resp1", {31'd0, m1_resp_o}, 32'd1);
      chk("r_rdata1", m1_rdata_o, 32'h30);
      chk("r_resp0", {31'd0, m0_resp_o}, 32'd0);
      tick();
      #1;
      chk("r_resp1_once", {31'd0, m1_resp_o}, 32'd0);
      chk("r_rdata1_hold", m1_rdata_o, 32'h30);
      chk("r_rdata0_keep", m0_rdata_o, 32'h0);

      // Both masters hold reads: grants alternate starting with m0.
      m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 32'h10;
      m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 32'h20;
      s_ack_i = 1'b1; s_resp_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         s_rdata_i = 32'h100 + i;
         #1;
         chk("rr_ack0", {31'd0, m0_ack_o}, {31'd0, (i % 2) == 0});
         chk("rr_ack1", {31'd0, m1_ack_o}, {31'd0, (i % 2) == 1});
         tick();
         tick();
         tick();
         #1;
         chk("rr_resp0", {31'd0, m0_resp_o}, {31'd0, (i % 2) == 0});
         chk("rr_resp1", {31'd0, m1_resp_o}, {31'd0, (i % 2) == 1});
         chk("rr_rdata", (i % 2) == 0 ? m0_rdata_o : m1_rdata_o, 32'h100 + i);
         if (i == 7) begin
            m0_req_i = 1'b0; m1_req_i = 1'b0;
         end
         tick();
      end
      s_ack_i = 1'b0; s_resp_i = 1'b0; s_rdata_i = 32'h0;

      // m0 writes 0..9 to 0x80000000.. then reads them back.
      for (int i = 0; i < 10; i++) m0_xfer(1'b1, 32'h8000_0000 + 4 * i, i, rd);
      for (int i = 0; i < 10; i++) begin
         m0_xfer(1'b0, 32'h8000_0000 + 4 * i, 32'h0, rd);
         chk("mem_rd", rd, i);
      end

      // m0 read to a slave that acks but never responds.
      m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 32'h40;
      #1;
      chk("to_ack", {31'd0, m0_ack_o}, 32'd1);
      tick();
      m0_req_i = 1'b0; s_ack_i = 1'b1;
      tick();
      s_ack_i = 1'b0; m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 32'h44;
`ifdef UDM_BUS_ARB_TIMEOUT_EN
      for (int c = 2; c < 16; c++) begin
         #1;
         chk("to_err_quiet", {31'd0, err_o}, 32'd0);
         chk("to_no_ack1", {31'd0, m1_ack_o}, 32'd0);
         tick();
      end
      #1;
      chk("to_err", {31'd0, err_o}, 32'd1);
      chk("to_sreq", {31'd0, s_req_o}, 32'd0);
      tick();
      #1;
      chk("to_err_once", {31'd0, err_o}, 32'd0);
      chk("to_resp0", {31'd0, m0_resp_o}, 32'd1);
      chk("to_rdata0", m0_rdata_o, 32'hDEADBEEF);
      tick();
      #1;
      chk("to_next_ack1", {31'd0, m1_ack_o}, 32'd1);
      tick();
      m1_req_i = 1'b0; s_ack_i = 1'b1;
      tick();
      s_ack_i = 1'b0;
`else
      for (int c = 0; c < 40; c++) begin
         #1;
         chk("hang_no_ack1", {31'd0, m1_ack_o}, 32'd0);
         chk("hang_no_resp0", {31'd0, m0_resp_o}, 32'd0);
         chk("hang_err", {31'd0, err_o}, 32'd0);
         chk("hang_sreq", {31'd0, s_req_o}, 32'd0);
         tick();
      end
      m1_req_i = 1'b0;
`endif

      // Reset while in RWAIT aborts the read; late response is ignored.
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0; s_resp_i = 1'b1; s_rdata_i = 32'h55;
      #1;
      chk("ab_sreq", {31'd0, s_req_o}, 32'd0);
      chk("ab_resp0", {31'd0, m0_resp_o}, 32'd0);
      chk("ab_resp1", {31'd0, m1_resp_o}, 32'd0);
      chk("ab_err", {31'd0, err_o}, 32'd0);
      tick();
      s_resp_i = 1'b0; s_rdata_i = 32'h0;
      #1;
      chk("ab_late_resp0", {31'd0, m0_resp_o}, 32'd0);
      chk("ab_late_resp1", {31'd0, m1_resp_o}, 32'd0);
      chk("ab_rdata0", m0_rdata_o, 32'h0);
      chk("ab_rdata1", m1_rdata_o, 32'h0);
      m0_req_i = 1'b1; m1_req_i = 1'b1;
      #1;
      chk("ab_tie_ack0", {31'd0, m0_ack_o}, 32'd1);
      chk("ab_tie_ack1", {31'd0, m1_ack_o}, 32'd0);
      tick();
      m0_req_i = 1'b0; m1_req_i = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
